// File: rtl/bb_msg_sched.sv
// Bounding-box report sequencer: every MSG_INTERVAL frames, snapshot five colour
// boxes and write a 3-word message per enabled, non-empty box into the CPU FIFO.
module bb_msg_sched #(
   parameter int MSG_INTERVAL = 6,
   parameter int FIFO_DEPTH   = 256,
   parameter bit SEND_EMPTY   = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         frame_done,
   input  logic [219:0] box_bus,
   input  logic [4:0]   colour_en,
   input  logic [7:0]   fifo_usedw,
   input  logic         msg_flush,
   output logic         msg_wr,
   output logic [31:0]  msg_data,
   output logic         busy,
   output logic [7:0]   drop_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SCAN  = 3'd1;
   localparam logic [2:0] S_WR_ID = 3'd2;
   localparam logic [2:0] S_WR_TL = 3'd3;
   localparam logic [2:0] S_WR_BR = 3'd4;

   // One word of slack beyond the 3-word message covers the usedw lag after WR_BR.
   localparam logic [8:0] SPACE_MAX = 9'(FIFO_DEPTH - 4);
   localparam logic [7:0] RELOAD    = 8'(MSG_INTERVAL - 1);

   logic [2:0]  state, state_nx;
   logic [2:0]  idx, idx_nx;
   logic        pending, pending_nx;
   logic [7:0]  frame_cnt;
   logic        start;
   logic [1:0]  drop_inc;

   logic [43:0] snap_box [5];
   logic [4:0]  snap_en;

   logic        trig;
   logic [43:0] cur_box;
   logic [10:0] x_min, y_min, x_max, y_max;
   logic        col_valid;
   logic        has_space;
   logic        last_col;
   logic [2:0]  adv_state;
   logic [2:0]  adv_idx;

   function automatic logic [7:0] colour_code(input logic [2:0] i);
      case (i)
         3'd0:    return 8'h52;
         3'd1:    return 8'h47;
         3'd2:    return 8'h42;
         3'd3:    return 8'h57;
         default: return 8'h59;
      endcase
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {7'd0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   assign trig      = frame_done && (frame_cnt == 8'd0);
   assign cur_box   = snap_box[idx];
   assign x_min     = cur_box[43:33];
   assign y_min     = cur_box[32:22];
   assign x_max     = cur_box[21:11];
   assign y_max     = cur_box[10:0];
   assign col_valid = snap_en[idx] && (SEND_EMPTY || ((x_min <= x_max) && (y_min <= y_max)));
   assign has_space = ({1'b0, fifo_usedw} <= SPACE_MAX);
   assign last_col  = (idx == 3'd4);
   assign adv_state = last_col ? S_IDLE : S_SCAN;
   assign adv_idx   = last_col ? 3'd0 : idx + 3'd1;

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      pending_nx = pending;
      start      = 1'b0;
      drop_inc   = 2'd0;
      if (msg_flush) begin
         state_nx   = S_IDLE;
         idx_nx     = 3'd0;
         pending_nx = 1'b0;
      end else begin
         if ((state != S_IDLE) && trig) begin
            if (pending) drop_inc = drop_inc + 2'd1;
            else         pending_nx = 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (trig || pending) begin
                  state_nx   = S_SCAN;
                  idx_nx     = 3'd0;
                  pending_nx = 1'b0;
                  start      = 1'b1;
               end
            end
            S_SCAN: begin
               if (col_valid && has_space) begin
                  state_nx = S_WR_ID;
               end else begin
                  if (col_valid) drop_inc = drop_inc + 2'd1;
                  state_nx = adv_state;
                  idx_nx   = adv_idx;
               end
            end
            S_WR_ID: state_nx = S_WR_TL;
            S_WR_TL: state_nx = S_WR_BR;
            S_WR_BR: begin
               state_nx = adv_state;
               idx_nx   = adv_idx;
            end
            default: begin
               state_nx = S_IDLE;
               idx_nx   = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= 3'd0;
         pending   <= 1'b0;
         frame_cnt <= 8'd0;
         drop_cnt  <= 8'd0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         pending  <= pending_nx;
         drop_cnt <= sat_add(drop_cnt, drop_inc);
         if (frame_done) frame_cnt <= (frame_cnt == 8'd0) ? RELOAD : frame_cnt - 8'd1;
      end
   end

   // Snapshot is pure data: only ever read after a start has loaded it.
   always_ff @(posedge clk) begin
      if (start) begin
         snap_en <= colour_en;
         for (int i = 0; i < 5; i++) snap_box[i] <= box_bus[44*i +: 44];
      end
   end

   always_comb begin
      msg_wr   = 1'b0;
      msg_data = 32'd0;
      case (state)
         S_WR_ID: begin
            msg_wr   = 1'b1;
            msg_data = {8'h00, colour_code(idx), 16'h4242};
         end
         S_WR_TL: begin
            msg_wr   = 1'b1;
            msg_data = {5'd0, x_min, 5'd0, y_min};
         end
         S_WR_BR: begin
            msg_wr   = 1'b1;
            msg_data = {5'd0, x_max, 5'd0, y_max};
         end
         default: ;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_bb_msg_sched.sv
// Bench for bb_msg_sched: three parameterisations share one stimulus stream, a
// queue-based report model is compared every cycle, plus literal spot checks.
module tb_bb_msg_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, frame_done, msg_flush;
   logic [219:0] box_bus;
   logic [4:0]   colour_en;
   logic [7:0]   fifo_usedw;

   logic         wr_o   [3];
   logic [31:0]  data_o [3];
   logic         busy_o [3];
   logic [7:0]   drop_o [3];

   bb_msg_sched #(.MSG_INTERVAL(1), .FIFO_DEPTH(256), .SEND_EMPTY(1'b0)) u_a (
      .clk(clk), .reset(reset), .frame_done(frame_done), .box_bus(box_bus),
      .colour_en(colour_en), .fifo_usedw(fifo_usedw), .msg_flush(msg_flush),
      .msg_wr(wr_o[0]), .msg_data(data_o[0]), .busy(busy_o[0]), .drop_cnt(drop_o[0]));

   bb_msg_sched #(.MSG_INTERVAL(6), .FIFO_DEPTH(256), .SEND_EMPTY(1'b0)) u_b (
      .clk(clk), .reset(reset), .frame_done(frame_done), .box_bus(box_bus),
      .colour_en(colour_en), .fifo_usedw(fifo_usedw), .msg_flush(msg_flush),
      .msg_wr(wr_o[1]), .msg_data(data_o[1]), .busy(busy_o[1]), .drop_cnt(drop_o[1]));

   bb_msg_sched #(.MSG_INTERVAL(1), .FIFO_DEPTH(256), .SEND_EMPTY(1'b1)) u_c (
      .clk(clk), .reset(reset), .frame_done(frame_done), .box_bus(box_bus),
      .colour_en(colour_en), .fifo_usedw(fifo_usedw), .msg_flush(msg_flush),
      .msg_wr(wr_o[2]), .msg_data(data_o[2]), .busy(busy_o[2]), .drop_cnt(drop_o[2]));

   int n_chk = 0;
   int n_pass = 0;

   int          wr_cnt    [3];
   int          start_cnt [3];
   int          busy_cyc  [3];
   bit          busy_prev [3];
   logic [31:0] wlog [1024];

   // Model: one entry per upcoming busy cycle; a scan entry expands into its writes.
   typedef struct {
      bit          scan;
      int          col;
      logic [31:0] data;
   } ent_t;

   int          P_INT [3] = '{1, 6, 1};
   bit          P_SE  [3] = '{1'b0, 1'b0, 1'b1};
   ent_t        q     [3][$];
   ent_t        m_cur [3];
   bit          m_act [3];
   int          m_fcnt[3];
   bit          m_pend[3];
   int          m_drop[3];
   logic [43:0] m_snap[3][5];
   logic [4:0]  m_en  [3];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   function automatic logic [31:0] id_word(input int c);
      logic [7:0] cc;
      case (c)
         0:       cc = 8'h52;
         1:       cc = 8'h47;
         2:       cc = 8'h42;
         3:       cc = 8'h57;
         default: cc = 8'h59;
      endcase
      return {8'h00, cc, 16'h4242};
   endfunction

   function automatic logic [43:0] bx(input int x0, input int y0, input int x1, input int y1);
      return {11'(x0), 11'(y0), 11'(x1), 11'(y1)};
   endfunction

   task automatic set_all(input logic [43:0] b);
      for (int i = 0; i < 5; i++) box_bus[44*i +: 44] = b;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_act[k] = 1'b0; q[k].delete(); m_fcnt[k] = 0; m_pend[k] = 1'b0; m_drop[k] = 0;
      end
   endtask

   task automatic model_step(input int k);
      bit          trig, valid;
      logic [43:0] b;
      ent_t        e;
      trig = frame_done && (m_fcnt[k] == 0);
      if (frame_done) m_fcnt[k] = (m_fcnt[k] == 0) ? P_INT[k] - 1 : m_fcnt[k] - 1;
      if (msg_flush) begin
         m_act[k] = 1'b0; q[k].delete(); m_pend[k] = 1'b0;
         return;
      end
      if (m_act[k]) begin
         if (trig) begin
            if (m_pend[k]) m_drop[k] = (m_drop[k] < 255) ? m_drop[k] + 1 : 255;
            else           m_pend[k] = 1'b1;
         end
         if (m_cur[k].scan) begin
            b = m_snap[k][m_cur[k].col];
            valid = m_en[k][m_cur[k].col] &&
                    (P_SE[k] || ((b[43:33] <= b[21:11]) && (b[32:22] <= b[10:0])));
            if (valid && (fifo_usedw <= 8'd252)) begin
               e.scan = 1'b0; e.col = m_cur[k].col;
               e.data = {5'd0, b[21:11], 5'd0, b[10:0]};  q[k].push_front(e);
               e.data = {5'd0, b[43:33], 5'd0, b[32:22]}; q[k].push_front(e);
               e.data = id_word(m_cur[k].col);            q[k].push_front(e);
            end else if (valid) begin
               m_drop[k] = (m_drop[k] < 255) ? m_drop[k] + 1 : 255;
            end
         end
         if (q[k].size() > 0) m_cur[k] = q[k].pop_front();
         else                 m_act[k] = 1'b0;
      end else if (trig || m_pend[k]) begin
         m_en[k] = colour_en;
         for (int i = 0; i < 5; i++) m_snap[k][i] = box_bus[44*i +: 44];
         m_pend[k] = 1'b0;
         m_act[k]  = 1'b1;
         q[k].delete();
         e.scan = 1'b1; e.data = 32'd0;
         e.col = 0; m_cur[k] = e;
         for (int c = 1; c < 5; c++) begin
            e.col = c; q[k].push_back(e);
         end
      end
   endtask

   task automatic compare(input int k);
      logic        ew;
      logic [31:0] ed;
      ew = m_act[k] && !m_cur[k].scan;
      ed = ew ? m_cur[k].data : 32'd0;
      chk($sformatf("u%0d msg_wr @%0t", k, $time), {31'd0, wr_o[k]}, {31'd0, ew});
      chk($sformatf("u%0d msg_data @%0t", k, $time), data_o[k], ed);
      chk($sformatf("u%0d busy @%0t", k, $time), {31'd0, busy_o[k]}, {31'd0, m_act[k]});
      chk($sformatf("u%0d drop_cnt @%0t", k, $time), {24'd0, drop_o[k]}, 32'(m_drop[k]));
      if (wr_o[k]) begin
         if (k == 0) wlog[wr_cnt[0] % 1024] = data_o[0];
         wr_cnt[k]++;
      end
      if (busy_o[k] && !busy_prev[k]) start_cnt[k]++;
      if (busy_o[k]) busy_cyc[k]++;
      busy_prev[k] = busy_o[k];
   endtask

   // One clock: compare at the falling edge, advance the model, return after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (reset) model_reset();
      for (int k = 0; k < 3; k++) compare(k);
      if (!reset) for (int k = 0; k < 3; k++) model_step(k);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse();
      frame_done = 1'b1; tick();
      frame_done = 1'b0; tick();
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); tick();
      reset = 1'b0; tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int base, base_c, bc, s, mask, found;
      reset = 1'b0; frame_done = 1'b0; msg_flush = 1'b0;
      colour_en = 5'h1F; fifo_usedw = 8'd0;
      set_all(bx(10, 20, 30, 40));
      for (int k = 0; k < 3; k++) begin
         wr_cnt[k] = 0; start_cnt[k] = 0; busy_cyc[k] = 0; busy_prev[k] = 1'b0;
      end
      model_reset();
      #2 reset = 1'b1;
      tick(); tick();
      chk("reset msg_wr", {31'd0, wr_o[0]}, 32'd0);
      chk("reset msg_data", data_o[0], 32'd0);
      chk("reset busy", {31'd0, busy_o[0]}, 32'd0);
      chk("reset drop_cnt", {24'd0, drop_o[0]}, 32'd0);
      reset = 1'b0; tick();

      // full report, every colour enabled
      base = wr_cnt[0]; bc = busy_cyc[0];
      pulse(); idle(22);
      chk("t1 writes", 32'(wr_cnt[0] - base), 32'd15);
      chk("t1 busy cycles", 32'(busy_cyc[0] - bc), 32'd20);
      chk("t1 word0", wlog[base % 1024], 32'h00524242);
      chk("t1 word1", wlog[(base + 1) % 1024], 32'h000A0014);
      chk("t1 word2", wlog[(base + 2) % 1024], 32'h001E0028);
      chk("t1 last id", wlog[(base + 12) % 1024], 32'h00594242);
      chk("t1 busy end", {31'd0, busy_o[0]}, 32'd0);

      // report interval of six frames
      do_reset();
      mask = 0; base = start_cnt[0];
      for (int p = 1; p <= 13; p++) begin
         s = start_cnt[1];
         pulse(); idle(23);
         if (start_cnt[1] != s) mask |= (1 << p);
      end
      chk("t2 start pulses", 32'(mask), 32'h2082);
      chk("t2 starts interval1", 32'(start_cnt[0] - base), 32'd13);

      // empty green box
      do_reset();
      box_bus[44 +: 44] = bx(600, 0, 0, 479);
      base = wr_cnt[0]; base_c = wr_cnt[2];
      pulse(); idle(22);
      found = 0;
      for (int i = 0; i < 12; i++) if (wlog[(base + i) % 1024] == 32'h00474242) found++;
      chk("t3 writes no-empty", 32'(wr_cnt[0] - base), 32'd12);
      chk("t3 green id absent", 32'(found), 32'd0);
      chk("t3 writes send-empty", 32'(wr_cnt[2] - base_c), 32'd15);
      set_all(bx(10, 20, 30, 40));

      // FIFO space threshold
      do_reset();
      fifo_usedw = 8'd253;
      base = wr_cnt[0];
      pulse(); idle(22);
      chk("t4 writes at 253", 32'(wr_cnt[0] - base), 32'd0);
      chk("t4 drops at 253", {24'd0, drop_o[0]}, 32'd5);
      fifo_usedw = 8'd252;
      base = wr_cnt[0];
      pulse(); idle(22);
      chk("t4 writes at 252", 32'(wr_cnt[0] - base), 32'd15);
      chk("t4 drops held", {24'd0, drop_o[0]}, 32'd5);
      fifo_usedw = 8'd0;

      // flush during the red top-left word
      do_reset();
      base = wr_cnt[0];
      pulse(); tick();
      chk("t5 in wr_tl", data_o[0], 32'h000A0014);
      msg_flush = 1'b1; tick();
      msg_flush = 1'b0;
      chk("t5 msg_wr after flush", {31'd0, wr_o[0]}, 32'd0);
      chk("t5 busy after flush", {31'd0, busy_o[0]}, 32'd0);
      chk("t5 partial writes", 32'(wr_cnt[0] - base), 32'd2);
      base = wr_cnt[0];
      pulse(); idle(22);
      chk("t5 restart red", wlog[base % 1024], 32'h00524242);
      chk("t5 restart writes", 32'(wr_cnt[0] - base), 32'd15);

      // flush coinciding with frame_done
      s = start_cnt[0];
      frame_done = 1'b1; msg_flush = 1'b1; tick();
      frame_done = 1'b0; msg_flush = 1'b0; idle(3);
      chk("t7 no start on flush", 32'(start_cnt[0] - s), 32'd0);
      pulse(); idle(22);
      chk("t7 next start", 32'(start_cnt[0] - s), 32'd1);

      // overrun, pending report, reset mid-report
      do_reset();
      s = start_cnt[0];
      pulse(); idle(3); pulse(); idle(3); pulse();
      chk("t6 drop after overrun", {24'd0, drop_o[0]}, 32'd1);
      for (int i = 0; i < 40 && (start_cnt[0] - s) < 2; i++) tick();
      chk("t6 pending run started", 32'(start_cnt[0] - s), 32'd2);
      idle(4);
      chk("t6 busy before reset", {31'd0, busy_o[0]}, 32'd1);
      reset = 1'b1; #1;
      chk("t6 reset msg_wr", {31'd0, wr_o[0]}, 32'd0);
      chk("t6 reset msg_data", data_o[0], 32'd0);
      chk("t6 reset busy", {31'd0, busy_o[0]}, 32'd0);
      chk("t6 reset drop_cnt", {24'd0, drop_o[0]}, 32'd0);
      tick(); tick();
      reset = 1'b0;
      base = wr_cnt[0];
      idle(30);
      chk("t6 no writes after reset", 32'(wr_cnt[0] - base), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bb_msg_sched.md
Name: bb_msg_sched

Overview:
Controller that sequences per-colour bounding-box reports into the CPU message FIFO. It replaces the single-colour three-state writer in the image processor. Every MSG_INTERVAL video frames it snapshots the five latched boxes (red, green, blue, grey, yellow) and walks them in order. For each enabled, non-empty box that fits in the FIFO it emits a 3-word message. It sits between the box-latch logic and the MSG_FIFO write port.

Parameters:
MSG_INTERVAL, 6, frames between report starts (1..255)
FIFO_DEPTH, 256, message FIFO capacity in words
SEND_EMPTY, 0, 1 = also report boxes with x_min > x_max or y_min > y_max

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_done  in  1  one-cycle pulse at eop of a video packet (eop & in_valid & packet_video)
box_bus  in  220  colour i in bits [44i+43:44i] = {x_min, y_min, x_max, y_max}, 11 bits each; i: 0 red, 1 green, 2 blue, 3 grey, 4 yellow
colour_en  in  5  per-colour report enable (CPU register), bit i = colour i
fifo_usedw  in  8  MSG_FIFO word count
msg_flush  in  1  CPU flush request (same pulse that clears the FIFO)
msg_wr  out  1  FIFO write strobe
msg_data  out  32  FIFO write word
busy  out  1  report in progress (state != IDLE)
drop_cnt  out  8  saturating count of dropped colour reports and overrun triggers

Behaviour:
- Reset (async, any state): state=IDLE, frame_cnt=0, idx=0, pending=0, drop_cnt=0, msg_wr=0, msg_data=0, busy=0. The first frame_done after reset triggers a report.
- Trigger: on frame_done, frame_cnt decrements if nonzero. If frame_cnt==0, it reloads to MSG_INTERVAL-1 and a trigger fires.
  - Trigger in IDLE: the next edge enters SCAN with idx=0, and box_bus and colour_en are captured into snapshot registers. Later input changes do not affect the current report.
  - Trigger while busy: sets pending. If pending is already 1, drop_cnt increments instead.
- States: IDLE, SCAN, WR_ID, WR_TL, WR_BR.
- SCAN takes one cycle per colour at snap[idx]:
  - valid = en & (SEND_EMPTY | (x_min<=x_max & y_min<=y_max)).
  - valid and fifo_usedw <= FIFO_DEPTH-4 -> WR_ID.
  - valid but no space -> drop_cnt+1 (saturating at 255), then advance.
  - not valid -> advance silently.
  - Advance: idx==4 -> IDLE, else idx+1 and stay in SCAN.
- Write sequence: WR_ID -> WR_TL -> WR_BR, one cycle each. After WR_BR: idx==4 -> IDLE, else idx+1 and SCAN.
  - The space threshold is -4, not -3, to tolerate a one-cycle usedw lag after WR_BR.
- msg_wr=1 exactly in the WR_* states. msg_data is valid in the same cycle. Both are Moore outputs from registered state, idx and snapshot.
  - WR_ID: {8'h00, C, 8'h42, 8'h42}, with C = 52 (R), 47 (G), 42 (B), 57 (W, grey), 59 (Y). Example: red = 32'h00524242.
  - WR_TL: {5'b0, x_min, 5'b0, y_min}.
  - WR_BR: {5'b0, x_max, 5'b0, y_max}.
  - msg_data = 0 outside the WR_* states.
- IDLE with pending=1: clears pending and starts a new report (snapshot taken that edge).
- Latency: trigger at edge t -> SCAN from t+1. An enabled colour 0 with space gives msg_wr in cycles t+2..t+4. A full report with all colours enabled takes 5 SCAN + 15 WR cycles.
- msg_flush:
  - In any state: the next state is IDLE and pending clears. A partial message is abandoned (the FIFO is cleared by the same pulse).
  - frame_cnt is unaffected.
  - msg_flush together with frame_done: flush wins and no report starts that cycle. frame_cnt still updates.
- drop_cnt never wraps. It is cleared only by reset.
- Arithmetic: all coordinate compares are unsigned 11-bit. frame_cnt is 8 bits.

Test Plan:
1. MSG_INTERVAL=1, colour_en=5'h1F, all boxes {10,20,30,40}, usedw=0, pulse frame_done -> 15 writes over 20 cycles. First three: 00524242, 000A0014, 001E0028. Last ID 00594242. busy drops after the final WR_BR.
2. MSG_INTERVAL=6, 13 frame_done pulses with idle gaps -> reports start on pulses 1, 7 and 13 only.
3. Green box {600,0,0,479} (empty), others valid, SEND_EMPTY=0 -> 12 writes, no 00474242. With SEND_EMPTY=1 -> 15 writes.
4. fifo_usedw held at 253, colour_en=5'h1F -> 0 writes, drop_cnt=5. With usedw=252 -> 15 writes.
5. msg_flush asserted during red WR_TL -> msg_wr low next cycle, state IDLE. The next trigger restarts at red.
6. Two frame_done pulses during one report, then reset asserted mid-report of the second -> pending run starts after the first. drop_cnt=1 from the second overrun. On reset, all outputs are 0 immediately, with no further writes.
